// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler uP and its program loader.
// Holds the program memory geometry (matches the uP PC / ROM), the loader
// sync byte and the loader state encoding.
package nibbler_pkg;

   localparam int unsigned PROG_ADDR_W  = 12;
   localparam int unsigned PROG_DATA_W  = 8;
   localparam logic [7:0]  LOADER_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      LD_IDLE   = 3'd0,
      LD_SYNC   = 3'd1,
      LD_LEN_HI = 3'd2,
      LD_LEN_LO = 3'd3,
      LD_DATA   = 3'd4,
      LD_CHK    = 3'd5,
      LD_DONE   = 3'd6,
      LD_ERR    = 3'd7
   } loader_state_e;

endpackage

// File: rtl/nibbler_prog_loader_if.sv
// Byte stream in / program memory write bus out of the program loader.
//   rx_valid, rx_data : incoming stream byte and its valid flag
//   rx_ready          : loader can accept a byte this cycle
//   mem_we            : program memory write strobe, one cycle per byte
//   mem_addr          : program memory write address
//   mem_wdata         : program memory write data
// Modport master is the loader (it masters the memory bus and answers the
// stream); modport slave is the surrounding system.
interface nibbler_prog_loader_if
   import nibbler_pkg::*;
#(
   parameter int unsigned ADDR_W = PROG_ADDR_W,
   parameter int unsigned DATA_W = PROG_DATA_W
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/nibbler_loader_timeout.sv
// Idle-cycle watchdog for the program loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count while high; counter is cleared while low
//   clr_i      : clear (reload to zero); has priority over expiry
//   expired_o  : high in the cycle that completes TIMEOUT idle cycles
module nibbler_loader_timeout #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_limit;

   // cnt_q holds the number of idle cycles already completed, so the
   // TIMEOUT-th idle cycle is the one where cnt_q == TIMEOUT-1.
   assign at_limit  = (cnt_q == CW'(TIMEOUT - 1));
   assign expired_o = en_i & ~clr_i & at_limit;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (!at_limit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nibbler_prog_loader.sv
// Nibbler program loader: receives a framed byte stream
// (MAGIC, LEN_HI, LEN_LO, N data bytes, CHK) and writes the data bytes into
// program memory from address 0, holding the uP in reset meanwhile.
//   clk, reset : clock, asynchronous active-low reset
//   start      : single-cycle load request (ignored while busy)
//   bus        : stream handshake in, program memory write bus out
//   cpu_hold   : hold the uP in reset while high
//   busy       : frame in progress
//   done, err  : sticky result of the last load
module nibbler_prog_loader
   import nibbler_pkg::*;
#(
   parameter int unsigned ADDR_W  = PROG_ADDR_W,
   parameter int unsigned DATA_W  = PROG_DATA_W,
   parameter logic [7:0]  MAGIC   = LOADER_MAGIC,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   nibbler_prog_loader_if.master bus,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] ST_IDLE   = LD_IDLE;
   localparam logic [2:0] ST_SYNC   = LD_SYNC;
   localparam logic [2:0] ST_LEN_HI = LD_LEN_HI;
   localparam logic [2:0] ST_LEN_LO = LD_LEN_LO;
   localparam logic [2:0] ST_DATA   = LD_DATA;
   localparam logic [2:0] ST_CHK    = LD_CHK;
   localparam logic [2:0] ST_DONE   = LD_DONE;
   localparam logic [2:0] ST_ERR    = LD_ERR;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        csum_q, csum_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              rx_ready;
   logic              accept;
   logic              tmo_en;
   logic              tmo_expired;
   logic [7:0]        chk_sum;
   logic [ADDR_W-1:0] len_full;

   always_comb begin
      rx_ready = 1'b0;
      tmo_en   = 1'b0;
      case (state_q)
         ST_SYNC:                             rx_ready = 1'b1;
         ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK: begin
            rx_ready = 1'b1;
            tmo_en   = 1'b1;
         end
         default: ;
      endcase
   end

   assign accept   = bus.rx_valid & rx_ready;
   assign chk_sum  = csum_q + bus.rx_data;
   assign len_full = {len_q[ADDR_W-1:8], bus.rx_data};

   nibbler_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (reset),
      .en_i      (tmo_en),
      .clr_i     (accept),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = addr_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = busy_q;
      hold_d      = hold_q;
      done_d      = done_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_SYNC;
               len_d   = '0;
               addr_d  = '0;
               csum_d  = '0;
               busy_d  = 1'b1;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_SYNC: begin
            if (accept && bus.rx_data == MAGIC) begin
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d[ADDR_W-1:8] = bus.rx_data[ADDR_W-9:0];
               state_d           = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d   = len_full;
               state_d = (len_full == '0) ? ST_CHK : ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = bus.rx_data;
               csum_d      = chk_sum;
               addr_d      = addr_q + 1'b1;
               // Compare the index, not the incremented address, so a
               // 4095-byte frame finishes without addr_q ever wrapping.
               if (addr_q == len_q - 1'b1) begin
                  state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (accept) begin
               busy_d = 1'b0;
               hold_d = 1'b0;
               if (chk_sum == 8'h00) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Expiry is already masked by an accept inside the watchdog.
      if (tmo_expired) begin
         state_d = ST_ERR;
         busy_d  = 1'b0;
         hold_d  = 1'b0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         addr_q      <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         hold_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.rx_ready  = rx_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_hold      = hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Self-checking bench for nibbler_prog_loader: table of whole frames plus
// hand-written sequences for timeout, start-while-busy and mid-load reset.
module tb_nibbler_prog_loader;
   import nibbler_pkg::*;

   localparam int unsigned TIMEOUT = 1024;

   // Frame bytes packed first-byte-in-MSB; expected writes likewise.
   typedef struct packed {
      logic [63:0] b;
      int          nb;
      int          ds;
      int          nw;
      logic [31:0] w;
      logic        done;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic cpu_hold, busy, done, err;

   nibbler_prog_loader_if #(.ADDR_W(PROG_ADDR_W), .DATA_W(PROG_DATA_W)) bus_if ();

   nibbler_prog_loader #(
      .ADDR_W  (PROG_ADDR_W),
      .DATA_W  (PROG_DATA_W),
      .MAGIC   (LOADER_MAGIC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus_if),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   int         wr_cyc[$];
   logic [11:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int         acc_edge[$];

   always @(negedge clk) begin
      if (bus_if.mem_we === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(bus_if.mem_addr);
         wr_data.push_back(bus_if.mem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Returns just after the posedge at which the byte is accepted.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = b;
      while (bus_if.rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus_if.rx_ready !== 1'b1) check("rx_ready_wait", 32'(bus_if.rx_ready), 32'h1);
      acc_edge.push_back(cyc + 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_logs();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      acc_edge.delete();
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      clear_logs();
      pulse_start();
      check({tag, "_start_status"}, {28'd0, busy, cpu_hold, done, err}, 32'hC);
      for (int j = 0; j < v.nb; j++) begin
         if (j == v.nb - 1) begin
            #1;
            check({tag, "_hold_before_chk"}, 32'(cpu_hold), 32'h1);
         end
         send_byte(v.b[63 - 8*j -: 8]);
      end
      idle();
      check({tag, "_hold_at_end"}, 32'(cpu_hold), 32'h0);
      repeat (2) @(negedge clk);
      check({tag, "_end_status"}, {28'd0, busy, cpu_hold, done, err}, {30'd0, v.done, v.err});
      check({tag, "_rx_ready_end"}, 32'(bus_if.rx_ready), 32'h0);
      check({tag, "_write_count"}, 32'(wr_addr.size()), 32'(v.nw));
      for (int k = 0; k < v.nw; k++) begin
         if (k < wr_addr.size() && v.ds + k < acc_edge.size()) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
            check($sformatf("%s_data%0d", tag, k), 32'(wr_data[k]), 32'(v.w[31 - 8*k -: 8]));
            check($sformatf("%s_cycle%0d", tag, k), 32'(wr_cyc[k]), 32'(acc_edge[v.ds + k]));
         end
      end
   endtask

   vec_t vec[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec[0] = '{b: 64'hA5_00_03_19_2F_40_78_00, nb: 7, ds: 3, nw: 3, w: 32'h19_2F_40_00, done: 1'b1, err: 1'b0};
      vec[1] = '{b: 64'hA5_00_03_19_2F_40_77_00, nb: 7, ds: 3, nw: 3, w: 32'h19_2F_40_00, done: 1'b0, err: 1'b1};
      vec[2] = '{b: 64'h00_3C_A5_00_01_55_AB_00, nb: 7, ds: 5, nw: 1, w: 32'h55_00_00_00, done: 1'b1, err: 1'b0};
      vec[3] = '{b: 64'hA5_00_00_00_00_00_00_00, nb: 4, ds: 3, nw: 0, w: 32'h0,         done: 1'b1, err: 1'b0};
      vec[4] = '{b: 64'hA5_F0_02_10_20_D0_00_00, nb: 6, ds: 3, nw: 2, w: 32'h10_20_00_00, done: 1'b1, err: 1'b0};

      bus_if.rx_valid = 1'b0;
      bus_if.rx_data  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {3'd0, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, busy, cpu_hold, done, err, bus_if.rx_ready},
            32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vec[i], $sformatf("vec%0d", i));

      // Timeout after two of five data bytes
      clear_logs();
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h11);
      send_byte(8'h22);
      idle();
      repeat (TIMEOUT - 1) @(negedge clk);
      check("tmo_before_limit", {28'd0, busy, cpu_hold, done, err}, 32'hC);
      @(negedge clk);
      check("tmo_at_limit", {28'd0, busy, cpu_hold, done, err}, 32'h1);
      check("tmo_write_count", 32'(wr_addr.size()), 32'h2);
      if (wr_data.size() == 2) check("tmo_second_write", {20'd0, wr_addr[1], wr_data[1]}, 32'h0_01_22);

      // start while busy is ignored
      clear_logs();
      pulse_start();
      send_byte(8'hA5);
      idle();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h55);
      send_byte(8'hAB);
      idle();
      repeat (2) @(negedge clk);
      check("busy_start_status", {28'd0, busy, cpu_hold, done, err}, 32'h2);
      check("busy_start_writes", 32'(wr_addr.size()), 32'h1);

      // Reset mid-DATA: the write pending for 0x22 must never appear
      clear_logs();
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      #1 reset = 1'b0;
      #1;
      check("midreset_outputs",
            {3'd0, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, busy, cpu_hold, done, err, bus_if.rx_ready},
            32'h0);
      bus_if.rx_data = 8'h33;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      idle();
      @(negedge clk);
      check("midreset_writes", 32'(wr_addr.size()), 32'h1);
      run_vec(vec[0], "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/nibbler_prog_loader.md
Name: nibbler_prog_loader

Overview:
- Writer side of the Nibbler program memory: the uP fetches 8-bit program bytes by 12-bit PC; this block loads those bytes.
- Receives a framed byte stream over a valid/ready handshake and writes it into program memory from address 0.
- Holds the uP in reset (cpu_hold) while a load is in progress.
- Reports completion or a checksum/timeout error.

Parameters:
ADDR_W, 12, program memory address width (matches PC width)
DATA_W, 8, program byte width
MAGIC, 8'hA5, sync byte that opens a frame
TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame before an error

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a load
rx_valid  input  1  rx_data holds a byte
rx_data  input  8  incoming stream byte
rx_ready  output  1  block can accept a byte this cycle
mem_we  output  1  program memory write strobe (one cycle per byte)
mem_addr  output  ADDR_W  program memory write address
mem_wdata  output  DATA_W  program memory write data
cpu_hold  output  1  hold the uP in reset while high
busy  output  1  a frame is in progress
done  output  1  sticky: last load succeeded
err  output  1  sticky: last load failed (checksum or timeout)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; length, address, checksum and timeout counters cleared. Reset mid-load abandons the frame, and no further mem_we is issued.
- Accept = rx_valid & rx_ready. rx_ready is a combinational function of state: 1 in SYNC, LEN_HI, LEN_LO, DATA and CHK; 0 otherwise.
- Frame format: MAGIC, LEN_HI (bits 3:0 = length[11:8]; bits 7:4 ignored), LEN_LO (length[7:0]), N data bytes, CHK.
- FSM transitions:
  - IDLE/DONE/ERR --start--> SYNC. Clear done, err, address and checksum; set busy and cpu_hold.
  - SYNC: an accepted byte equal to MAGIC goes to LEN_HI. Any other byte is discarded and the block stays in SYNC. There is no timeout in SYNC.
  - LEN_HI --accept--> LEN_LO.
  - LEN_LO --accept--> DATA if N>0, else CHK.
  - DATA: each accepted byte adds to the running checksum (8-bit, mod 256) and is written. After the Nth byte go to CHK.
  - CHK --accept--> DONE if (checksum + CHK) mod 256 == 0, else ERR.
  - Entering DONE or ERR: busy=0, cpu_hold=0; done or err set to 1 (sticky until the next start).
- Write timing: mem_we, mem_addr and mem_wdata are registered. A byte accepted in cycle t is written with mem_we=1 in cycle t+1 at address k (k = byte index 0..N-1); mem_we=0 in every other cycle. mem_addr holds its last value when idle.
- N=4095 is the maximum. The address never wraps inside a frame.
- Timeout: in LEN_HI, LEN_LO, DATA and CHK, a counter counts cycles without an accept and clears on every accept. When it reaches TIMEOUT, go to ERR. Bytes already written are not rolled back.
- start while busy is ignored. start in DONE or ERR restarts the load.
- An accept and a timeout in the same cycle: the accept wins.
- The final data byte's mem_we (cycle t+1) may coincide with the transition into CHK; both occur.

Decomposition:
- Shared package nibbler_pkg holds:
  - the loader state enum (IDLE, SYNC, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR)
  - PROG_ADDR_W=12 and PROG_DATA_W=8, shared with the uP PC/ROM
  - LOADER_MAGIC
- One natural sub-module: nibbler_loader_timeout, a loadable idle counter with a clear input and an expiry flag.
- The FSM, checksum and address counter stay in the top module.

Test Plan:
- Reset, then start; send A5, 00, 03, 19, 2F, 40, 78: writes 19@0, 2F@1, 40@2, each one cycle after its accept; done=1, err=0, cpu_hold falls on the DONE entry, 0x19+0x2F+0x40+0x78 = 0x100.
- Same frame with CHK=77: all three writes still occur; err=1, done=0.
- Send 00, 3C, A5, 00, 01, 55, AB: 00 and 3C are discarded in SYNC; a single write 55@0; done=1.
- Frame with N=0 (A5, 00, 00, 00): no mem_we at all; done=1.
- Send A5, 00, 05 and two data bytes, then hold rx_valid=0 for TIMEOUT cycles: err=1, exactly 2 writes, busy=0.
- Drop reset to 0 mid-DATA: all outputs go to 0 immediately and no further writes occur; a new start plus a full frame then completes with done=1.
